// File: rtl/input_layer_pkg.sv
// Shared types and constants for the input-layer FIFO sequencing logic.
package input_layer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WORD_BYTES = 8;
  localparam int PIX_BYTES  = 3;

  // Number of 64-bit upstream words that carry one whole frame of 24-bit pixels.
  function automatic int frame_words(input int img_w, input int img_h);
    return (img_w * img_h * PIX_BYTES) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/input_fifo_ctrl.sv
// Frame sequencer around the 64-in / 24-out byte FIFO: admits upstream words
// only when they fit, pops pixels into a registered downstream port, and tags
// every pixel with its coordinates and end-of-row / end-of-frame flags.
module input_fifo_ctrl
  import input_layer_pkg::*;
#(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int FIFO_BYTES = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  input  logic [63:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [63:0]                fifo_data_in,
  output logic                       fifo_push,
  output logic                       fifo_pop,
  input  logic [23:0]                fifo_data_o,
  input  logic [3:0]                 fifo_count,
  output logic [23:0]                pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [$clog2(IMG_W)-1:0]   pix_x,
  output logic [$clog2(IMG_H)-1:0]   pix_y,
  output logic                       pix_eol,
  output logic                       pix_eof
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWORDS = frame_words(IMG_W, IMG_H);
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int WLW    = $clog2(NWORDS + 1);
  localparam int PLW    = $clog2(NPIX + 1);

  // Occupancy thresholds: a word fits outright, or fits because a pixel leaves in the same cycle.
  localparam logic [3:0] POP_MIN       = 4'(PIX_BYTES);
  localparam logic [3:0] PUSH_ROOM     = 4'(FIFO_BYTES - WORD_BYTES);
  localparam logic [3:0] PUSH_POP_ROOM = 4'(FIFO_BYTES - WORD_BYTES + PIX_BYTES);

  // A frame must be a whole number of upstream words, otherwise the last word straddles frames.
  if ((IMG_W * IMG_H) % WORD_BYTES != 0) begin : g_bad_frame_size
    $error("input_fifo_ctrl: IMG_W*IMG_H must be a multiple of 8");
  end

  state_e           state_q, state_d;
  logic [WLW-1:0]   words_left_q, words_left_d;
  logic [PLW-1:0]   pix_left_q, pix_left_d;
  logic [23:0]      pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d;
  logic [XW-1:0]    pix_x_q, pix_x_d;
  logic [YW-1:0]    pix_y_q, pix_y_d;
  logic             pix_eof_q, pix_eof_d;
  logic [XW-1:0]    next_x_q, next_x_d;
  logic [YW-1:0]    next_y_q, next_y_d;
  logic             pop_ok;
  logic             s_ready_c;
  logic             push_c;
  logic             frame_done_c;

  // Next-state logic: frame bookkeeping, admission control and the pixel output register.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    pix_left_d   = pix_left_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_eof_d    = pix_eof_q;
    next_x_d     = next_x_q;
    next_y_d     = next_y_q;
    pop_ok       = 1'b0;
    s_ready_c    = 1'b0;
    push_c       = 1'b0;
    frame_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          words_left_d = WLW'(NWORDS);
          pix_left_d   = PLW'(NPIX);
          pix_data_d   = '0;
          pix_valid_d  = 1'b0;
          pix_x_d      = '0;
          pix_y_d      = '0;
          pix_eof_d    = 1'b0;
          next_x_d     = '0;
          next_y_d     = '0;
        end
      end
      RUN: begin
        pop_ok       = (pix_left_q != '0) && (fifo_count >= POP_MIN) &&
                       (!pix_valid_q || pix_ready);
        s_ready_c    = (words_left_q != '0) &&
                       ((fifo_count <= PUSH_ROOM) || (pop_ok && (fifo_count <= PUSH_POP_ROOM)));
        push_c       = s_valid && s_ready_c;
        frame_done_c = pix_valid_q && pix_ready && pix_eof_q;
        if (push_c) begin
          words_left_d = words_left_q - WLW'(1);
        end
        if (pop_ok) begin
          pix_data_d  = fifo_data_o;
          pix_valid_d = 1'b1;
          pix_x_d     = next_x_q;
          pix_y_d     = next_y_q;
          pix_eof_d   = (pix_left_q == PLW'(1));
          pix_left_d  = pix_left_q - PLW'(1);
          if (next_x_q == XW'(IMG_W - 1)) begin
            next_x_d = '0;
            next_y_d = (next_y_q == YW'(IMG_H - 1)) ? '0 : next_y_q + YW'(1);
          end else begin
            next_x_d = next_x_q + XW'(1);
          end
        end else if (pix_valid_q && pix_ready) begin
          pix_valid_d = 1'b0;
        end
        if (frame_done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      pix_left_q   <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_eof_q    <= 1'b0;
      next_x_q     <= '0;
      next_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      pix_left_q   <= pix_left_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_eof_q    <= pix_eof_d;
      next_x_q     <= next_x_d;
      next_y_q     <= next_y_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign frame_done   = frame_done_c;
  assign s_ready      = s_ready_c;
  assign fifo_data_in = s_data;
  assign fifo_push    = push_c;
  assign fifo_pop     = pop_ok;
  assign pix_data     = pix_data_q;
  assign pix_valid    = pix_valid_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_eol      = (pix_x_q == XW'(IMG_W - 1));
  assign pix_eof      = pix_eof_q;

endmodule

// File: tb/tb_input_fifo_ctrl.sv
// Self-checking bench for input_fifo_ctrl on a 4x2 frame, with a behavioural
// byte FIFO standing in for reg_fifo and a scoreboard of expected pixels.
`timescale 1ns/1ps
module tb_input_fifo_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPIX  = W * H;
  localparam int NWORD = NPIX * 3 / 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frameDone;
  logic [63:0] sData;
  logic        sValid;
  logic        sReady;
  logic [63:0] fifoDataIn;
  logic        fifoPush;
  logic        fifoPop;
  logic [23:0] fifoHead;
  logic [3:0]  fifoCount;
  logic [23:0] pixData;
  logic        pixValid;
  logic        pixReady;
  logic [1:0]  pixX;
  logic        pixY;
  logic        pixEol;
  logic        pixEof;

  typedef struct {
    logic [23:0] data;
    int          x;
    int          y;
    bit          eol;
    bit          eof;
  } expT;

  expT         expQ[$];
  logic [7:0]  fq[$];
  logic [63:0] frameWords[NWORD];
  int          tests = 0;
  int          fails = 0;
  int          pixSeen = 0;
  int          doneCount = 0;
  bit          doneSeen = 0;

  always #5 clk = ~clk;

  input_fifo_ctrl #(.IMG_W(W), .IMG_H(H), .FIFO_BYTES(15)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frameDone),
    .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .fifo_data_in(fifoDataIn), .fifo_push(fifoPush), .fifo_pop(fifoPop),
    .fifo_data_o(fifoHead), .fifo_count(fifoCount),
    .pix_data(pixData), .pix_valid(pixValid), .pix_ready(pixReady),
    .pix_x(pixX), .pix_y(pixY), .pix_eol(pixEol), .pix_eof(pixEof)
  );

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Everything the DUT drives must read zero while held in reset.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_s_ready"}, sReady, 0);
    checkOutput({tag, "_fifo_pop"}, fifoPop, 0);
    checkOutput({tag, "_fifo_push"}, fifoPush, 0);
    checkOutput({tag, "_frame_done"}, frameDone, 0);
    checkOutput({tag, "_pix_valid"}, pixValid, 0);
    checkOutput({tag, "_pix_data"}, pixData, 0);
    checkOutput({tag, "_pix_x"}, pixX, 0);
    checkOutput({tag, "_pix_y"}, pixY, 0);
    checkOutput({tag, "_pix_eol"}, pixEol, 0);
    checkOutput({tag, "_pix_eof"}, pixEof, 0);
  endtask

  // Behavioural byte FIFO: 64-bit words enter low byte first, pixels leave as three bytes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      fifoCount <= '0;
      fifoHead  <= '0;
    end else begin
      if (fifoPop) begin
        checkOutput("pop_has_pixel", (fq.size() >= 3), 1);
        if (fq.size() >= 3) begin
          repeat (3) void'(fq.pop_front());
        end
      end
      if (fifoPush) begin
        checkOutput("push_fits", (fq.size() + 8 <= 15), 1);
        if (fq.size() + 8 <= 15) begin
          for (int j = 0; j < 8; j++) fq.push_back(fifoDataIn[8*j +: 8]);
        end
      end
      fifoCount <= 4'(fq.size());
      fifoHead  <= (fq.size() >= 3) ? {fq[2], fq[1], fq[0]} : 24'h0;
    end
  end

  // Monitor: pops the scoreboard on every downstream handshake and checks the protocol rules.
  always begin : monitor
    bit          prevHold;
    logic [23:0] holdData;
    logic [1:0]  holdX;
    logic        holdY;
    expT         e;
    prevHold = 0;
    holdData = '0;
    holdX    = '0;
    holdY    = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prevHold = 0;
      end else begin
        if (prevHold) begin
          checkOutput("hold_valid", pixValid, 1);
          checkOutput("hold_data", pixData, holdData);
          checkOutput("hold_x", pixX, holdX);
          checkOutput("hold_y", pixY, holdY);
        end
        if (pixValid && pixReady) begin
          pixSeen++;
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_pixel: got data %0h, expected no pixel", pixData);
          end else begin
            e = expQ.pop_front();
            checkOutput("pix_data", pixData, e.data);
            checkOutput("pix_x", pixX, e.x);
            checkOutput("pix_y", pixY, e.y);
            checkOutput("pix_eol", pixEol, e.eol);
            checkOutput("pix_eof", pixEof, e.eof);
            checkOutput("frame_done", frameDone, e.eof);
          end
          if (frameDone) begin
            doneSeen = 1;
            doneCount++;
            checkOutput("count_at_done", fifoCount, 0);
          end
        end else begin
          checkOutput("done_without_handshake", frameDone, 0);
        end
        if (fifoCount < 3) checkOutput("no_pop_when_low", fifoPop, 0);
        if (fifoCount > 10 || (fifoCount > 7 && !fifoPop)) checkOutput("s_ready_when_full", sReady, 0);
        prevHold = pixValid && !pixReady;
        holdData = pixData;
        holdX    = pixX;
        holdY    = pixY;
      end
    end
  end

  // Runs one frame from frameWords. Entered and left at 3 ns after a falling edge.
  // vm: 0 valid held, 1 toggling, 2 random; rm: 0 ready held, 1 stall 20 cycles, 2 random.
  task automatic applyStimulus(input int vm, input int rm, input bit midStart, input bit extra,
                               input int abortAt, input bit startAtDone);
    logic [7:0] b[NWORD*8];
    int cyc, idx, stallLeft, doneBefore;
    bit tog, stallStarted;
    for (int i = 0; i < NWORD; i++)
      for (int j = 0; j < 8; j++) b[8*i+j] = frameWords[i][8*j +: 8];
    for (int k = 0; k < NPIX; k++)
      expQ.push_back('{data: {b[3*k+2], b[3*k+1], b[3*k]}, x: k % W, y: k / W,
                       eol: (k % W == W - 1), eof: (k == NPIX - 1)});
    pixSeen = 0; doneSeen = 0; doneBefore = doneCount;
    cyc = 0; idx = 0; tog = 1; stallStarted = 0; stallLeft = 0;
    start = 1; sValid = 0; pixReady = 1;
    while (!doneSeen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = midStart && (cyc == 6);
      if (cyc == 1) checkOutput("busy_after_start", busy, 1);
      case (vm)
        0: sValid = (idx < NWORD) || extra;
        1: begin sValid = ((idx < NWORD) || extra) && tog; tog = !tog; end
        default: sValid = ((idx < NWORD) || extra) && ($urandom_range(0, 1) == 1);
      endcase
      sData = (idx < NWORD) ? frameWords[idx] : {$urandom, $urandom};
      case (rm)
        0: pixReady = 1;
        1: begin
          if (!stallStarted && pixValid) begin stallStarted = 1; stallLeft = 20; end
          if (stallLeft > 0) begin pixReady = 0; stallLeft--; end
          else pixReady = 1;
        end
        default: pixReady = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (sValid) begin
        if (idx < NWORD) begin
          if (sReady) idx++;
        end else begin
          checkOutput("s_ready_after_last_word", sReady, 0);
        end
      end
      #2;
      if (abortAt > 0 && pixSeen >= abortAt) begin
        @(negedge clk);
        #3;
        reset = 1;
        #1;
        checkIdle("abort");
        expQ.delete();
        sValid = 0;
        start  = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #3;
        return;
      end
    end
    checkOutput("frame_finished", doneSeen, 1);
    checkOutput("busy_at_done", busy, 1);
    checkOutput("words_pushed", idx, NWORD);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    checkOutput("done_pulses_in_frame", doneCount - doneBefore, 1);
    expQ.delete();
    sValid = 0;
    if (startAtDone) start = 1;
    @(negedge clk);
    start = 0;
    checkOutput("busy_after_done", busy, 0);
    #3;
  endtask

  initial begin
    int d0;
    reset = 1; start = 0; sValid = 0; sData = '0; pixReady = 0;
    #12;
    checkIdle("reset");
    @(negedge clk);
    reset = 0;
    #3;

    frameWords[0] = 64'h2343253267384758;
    frameWords[1] = 64'h4567485739576944;
    frameWords[2] = 64'h0011223344556677;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    d0 = doneCount;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("two_frames_done", doneCount - d0, 2);

    repeat (6) begin
      for (int i = 0; i < NWORD; i++) frameWords[i] = {$urandom, $urandom};
      applyStimulus(2, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_fifo_ctrl.md
Name: input_fifo_ctrl

Overview:
- Frame-level sequencer for the 64-bit-in / 24-bit-out byte FIFO (reg_fifo) at the front of the input layer.
- Admits 64-bit words from an upstream valid/ready stream into the FIFO only when there is room, and pops 24-bit pixels into a registered downstream valid/ready port.
- Tags each pixel with x/y coordinates and end-of-row/end-of-frame flags, and runs exactly one IMG_W x IMG_H frame per start pulse.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame. IMG_W*IMG_H must be a multiple of 8, so a frame is a whole number of 64-bit words (elaboration-time check).
- FIFO_BYTES, 15, FIFO byte capacity, matching the 4-bit fifo_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset. The top level drives reg_fifo reset_n = ~reset.
- start  in  1  one-cycle frame start pulse; ignored while busy.
- busy  out  1  high from the cycle after accepted start until frame_done.
- frame_done  out  1  one-cycle pulse when the last pixel handshakes downstream.
- s_data  in  64  upstream word.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- fifo_data_in  out  64  to reg_fifo data_in; equals s_data.
- fifo_push  out  1  to reg_fifo push.
- fifo_pop  out  1  to reg_fifo pop.
- fifo_data_o  in  24  reg_fifo head pixel; valid combinationally while fifo_count>=3.
- fifo_count  in  4  reg_fifo occupancy in bytes; updates at the edge that executes push/pop.
- pix_data  out  24  registered pixel.
- pix_valid  out  1  downstream valid.
- pix_ready  in  1  downstream ready.
- pix_x  out  $clog2(IMG_W)  column of pix_data.
- pix_y  out  $clog2(IMG_H)  row of pix_data.
- pix_eol  out  1  pix_x==IMG_W-1.
- pix_eof  out  1  last pixel of the frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-frame aborts immediately; the FIFO is cleared by the same reset.
- States and transitions:
  - IDLE: start -> RUN. Load words_left = IMG_W*IMG_H*3/8 and pix_left = IMG_W*IMG_H.
  - RUN: -> IDLE when the last pixel handshakes (pix_valid & pix_ready & pix_eof). frame_done pulses in that same cycle; busy drops the next cycle.
- pop_ok = (state==RUN) & pix_left>0 & fifo_count>=3 & (!pix_valid | pix_ready).
- fifo_pop = pop_ok. On a pop, fifo_data_o is registered into pix_data with pix_valid=1 next cycle (1-cycle latency); pix_left decrements.
- s_ready = (state==RUN) & words_left>0 & (fifo_count<=FIFO_BYTES-8 | (pop_ok & fifo_count<=FIFO_BYTES-5)).
- fifo_push = s_valid & s_ready; a push decrements words_left. Simultaneous push and pop are allowed.
- Downstream handshake:
  - pix_valid holds with pix_data, pix_x and pix_y stable until pix_ready.
  - On handshake with no new pop, pix_valid clears.
  - Back-to-back pops sustain 1 pixel/cycle while the FIFO holds >=3 bytes.
- Coordinates:
  - pix_x advances on each pop and wraps at IMG_W-1 to 0, incrementing pix_y.
  - pix_y wraps to 0 after IMG_H-1.
  - Both reset to 0 at start.
- End of frame: fifo_count is 0 when frame_done pulses, because the frame byte count is a multiple of 8 and of 3. An extra s_valid after words_left==0 is not accepted (s_ready=0).
- start in RUN: ignored. start in the same cycle as frame_done: ignored; it must be reissued.

Decomposition:
- Package input_layer_pkg:
  - FSM state enum (IDLE, RUN).
  - Localparams WORD_BYTES=8 and PIX_BYTES=3.
  - Helper function for frame word count.
- No sub-module. reg_fifo is instantiated beside this block at the input-layer top, not inside it.

Test Plan:
- IMG_W=4, IMG_H=2, pix_ready=1, s_valid held 1 with words 64'h2343253267384758, 64'h4567485739576944, 64'h0011223344556677 -> exactly 3 pushes, 8 pixels with (x,y) = (0,0)..(3,1), pix_eol on x=3, pix_eof and frame_done on pixel 8, fifo_count=0 after.
- Same frame, pix_ready=0 for 20 cycles after the first pix_valid -> pix_data/pix_x stable; s_ready drops once fifo_count>7; no push overflows (fifo_count never >15); all 8 pixels later delivered in order.
- s_valid toggled 1/0 every cycle -> no pop while fifo_count<3; pixel sequence identical to scenario 1.
- start pulsed again mid-frame and a 4th word offered after 3 accepted -> second start ignored; s_ready=0 for the 4th word; busy falls one cycle after frame_done.
- reset asserted asynchronously after pixel 3 -> all outputs 0 immediately and state IDLE; a new start runs a full 8-pixel frame from (0,0).
- Two consecutive frames with start one cycle after the first frame_done -> coordinates restart at (0,0); two frame_done pulses total.
